// File: rtl/s2mm_dma_module.sv
// Stream-to-memory DMA: buffers a 64-bit valid/ready stream and writes it to memory
// as fixed-length AXI3 INCR bursts on the ACP port, one burst in flight at a time.
module s2mm_dma_module #(
    parameter int unsigned DATA_SIZE     = 345600,
    parameter int unsigned DATA_SIZE_LOG = 19,
    parameter int unsigned BURST_SIZE    = 16,
    parameter int unsigned FIFO_DEPTH    = 32
) (
    input  logic        m_axi_acp_aclk,
    input  logic        axi_resetn,
    input  logic        start,
    input  logic [31:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  m_axi_acp_awid,
    output logic [31:0] m_axi_acp_awaddr,
    output logic [3:0]  m_axi_acp_awlen,
    output logic [2:0]  m_axi_acp_awsize,
    output logic [1:0]  m_axi_acp_awburst,
    output logic [1:0]  m_axi_acp_awlock,
    output logic [3:0]  m_axi_acp_awcache,
    output logic [2:0]  m_axi_acp_awprot,
    output logic [3:0]  m_axi_acp_awqos,
    output logic [4:0]  m_axi_acp_awuser,
    output logic        m_axi_acp_awvalid,
    input  logic        m_axi_acp_awready,
    output logic [2:0]  m_axi_acp_wid,
    output logic [63:0] m_axi_acp_wdata,
    output logic [7:0]  m_axi_acp_wstrb,
    output logic        m_axi_acp_wlast,
    output logic [4:0]  m_axi_acp_wuser,
    output logic        m_axi_acp_wvalid,
    input  logic        m_axi_acp_wready,
    input  logic [2:0]  m_axi_acp_bid,
    input  logic [1:0]  m_axi_acp_bresp,
    input  logic [4:0]  m_axi_acp_buser,
    input  logic        m_axi_acp_bvalid,
    output logic        m_axi_acp_bready,
    input  logic [63:0] s2mm_data,
    input  logic        s2mm_valid,
    output logic        s2mm_ready
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [DATA_SIZE_LOG-1:0] TotalBeats = DATA_SIZE_LOG'(DATA_SIZE);
    localparam logic [DATA_SIZE_LOG-1:0] LastBurst  = DATA_SIZE_LOG'(DATA_SIZE / BURST_SIZE - 1);
    localparam logic [DATA_SIZE_LOG-1:0] OneW       = DATA_SIZE_LOG'(1);
    localparam logic [CntW-1:0]          BurstCnt   = CntW'(BURST_SIZE);
    localparam logic [CntW-1:0]          FifoFull   = CntW'(FIFO_DEPTH);
    localparam logic [3:0]               BeatLast   = 4'(BURST_SIZE - 1);
    localparam logic [31:0]              BurstBytes = 32'(BURST_SIZE * 8);

    typedef enum logic [2:0] {StIdle, StFill, StAddr, StData, StResp} state_e;

    state_e                   state_q, state_d;
    logic [31:0]              awaddr_q;
    logic [DATA_SIZE_LOG-1:0] beats_in_q, bursts_done_q;
    logic [3:0]               beat_cnt_q;
    logic                     busy_q, done_q, err_q;
    logic [63:0]              fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]          count_q;
    logic                     start_acc, push, pop, b_hs, last_b;
    logic                     unused_b;

    assign unused_b = ^{m_axi_acp_bid, m_axi_acp_buser};

    assign start_acc = start && (state_q == StIdle);
    // Beats past the transfer length are refused so the stream never over-delivers.
    assign s2mm_ready = busy_q && (count_q != FifoFull) && (beats_in_q < TotalBeats);
    assign push       = s2mm_valid && s2mm_ready;

    assign m_axi_acp_awvalid = (state_q == StAddr);
    assign m_axi_acp_wvalid  = (state_q == StData) && (count_q != '0);
    assign m_axi_acp_wlast   = (state_q == StData) && (beat_cnt_q == BeatLast);
    assign m_axi_acp_bready  = (state_q == StResp);
    assign pop    = m_axi_acp_wvalid && m_axi_acp_wready;
    assign b_hs   = m_axi_acp_bready && m_axi_acp_bvalid;
    assign last_b = b_hs && (bursts_done_q == LastBurst);

    assign m_axi_acp_awid    = 3'b100;
    assign m_axi_acp_awaddr  = awaddr_q;
    assign m_axi_acp_awlen   = BeatLast;
    assign m_axi_acp_awsize  = 3'b011;
    assign m_axi_acp_awburst = 2'b01;
    assign m_axi_acp_awlock  = 2'b00;
    assign m_axi_acp_awcache = 4'b0001;
    assign m_axi_acp_awprot  = 3'b000;
    assign m_axi_acp_awqos   = 4'b0000;
    assign m_axi_acp_awuser  = 5'b00000;
    assign m_axi_acp_wid     = 3'b100;
    assign m_axi_acp_wdata   = fifo_mem[rd_ptr_q];
    assign m_axi_acp_wstrb   = 8'hFF;
    assign m_axi_acp_wuser   = 5'b00000;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_acc) state_d = StFill;
            StFill: if (count_q >= BurstCnt) state_d = StAddr;
            StAddr: if (m_axi_acp_awready) state_d = StData;
            StData: if (pop && m_axi_acp_wlast) state_d = StResp;
            StResp: if (m_axi_acp_bvalid) state_d = last_b ? StIdle : StFill;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state_q <= StIdle;
        else             state_q <= state_d;
    end

    always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            awaddr_q      <= '0;
            beats_in_q    <= '0;
            bursts_done_q <= '0;
            beat_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= last_b;
            if (start_acc) begin
                // 128-byte alignment keeps every burst inside one 4 KB page.
                awaddr_q      <= {dst_addr[31:7], 7'b0};
                beats_in_q    <= '0;
                bursts_done_q <= '0;
                err_q         <= 1'b0;
                busy_q        <= 1'b1;
            end
            if (push) beats_in_q <= beats_in_q + OneW;
            if (pop)  beat_cnt_q <= m_axi_acp_wlast ? 4'd0 : beat_cnt_q + 4'd1;
            if (b_hs) begin
                err_q         <= err_q | (m_axi_acp_bresp != 2'b00);
                bursts_done_q <= bursts_done_q + OneW;
                awaddr_q      <= awaddr_q + BurstBytes;
                if (last_b) busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge m_axi_acp_aclk) begin
        if (push) fifo_mem[wr_ptr_q] <= s2mm_data;
    end

endmodule

// File: tb/tb_s2mm_dma_module.sv
// Randomized bench for s2mm_dma_module: a stream source, an AXI write slave and a
// transaction-level model (expected-data queue, address arithmetic, beat counts).
module tb_s2mm_dma_module;
    localparam int DS = 64;
    localparam int BS = 16;
    localparam int FD = 32;
    localparam int NB = DS / BS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_addr = '0;
    logic        busy, done, err;
    logic [2:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic [4:0]  awuser;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [2:0]  wid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic [4:0]  wuser;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;

    always #5 clk = ~clk;

    s2mm_dma_module #(
        .DATA_SIZE(DS), .DATA_SIZE_LOG(7), .BURST_SIZE(BS), .FIFO_DEPTH(FD)
    ) dut (
        .m_axi_acp_aclk(clk), .axi_resetn(rst_n), .start(start), .dst_addr(dst_addr),
        .busy(busy), .done(done), .err(err),
        .m_axi_acp_awid(awid), .m_axi_acp_awaddr(awaddr), .m_axi_acp_awlen(awlen),
        .m_axi_acp_awsize(awsize), .m_axi_acp_awburst(awburst), .m_axi_acp_awlock(awlock),
        .m_axi_acp_awcache(awcache), .m_axi_acp_awprot(awprot), .m_axi_acp_awqos(awqos),
        .m_axi_acp_awuser(awuser), .m_axi_acp_awvalid(awvalid), .m_axi_acp_awready(awready),
        .m_axi_acp_wid(wid), .m_axi_acp_wdata(wdata), .m_axi_acp_wstrb(wstrb),
        .m_axi_acp_wlast(wlast), .m_axi_acp_wuser(wuser), .m_axi_acp_wvalid(wvalid),
        .m_axi_acp_wready(wready), .m_axi_acp_bid(3'b100), .m_axi_acp_bresp(bresp),
        .m_axi_acp_buser(5'b0), .m_axi_acp_bvalid(bvalid), .m_axi_acp_bready(bready),
        .s2mm_data(s_data), .s2mm_valid(s_valid), .s2mm_ready(s_ready)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Stimulus knobs
    int          aw_delay = 0;
    int          w_ready_pct = 100;
    int          s_valid_pct = 100;
    int          bad_idx = -1;
    logic [1:0]  bad_resp = 2'b10;
    bit          start_req = 0;
    logic [31:0] start_addr = '0;

    // Reference model state
    logic [63:0] exp_q[$];
    logic [63:0] src_data = 64'h0123_4567_89ab_cdef;
    logic [31:0] base_addr = '0;
    logic [31:0] aw_hold_addr = '0;
    int  pushes = 0, pops = 0, aw_hs_n = 0, b_n = 0, w_bursts = 0, w_beat = 0;
    int  aw_wait = 0, done_seen = 0;
    bit  m_busy = 0, m_err = 0, m_done_next = 0, xfer_done = 0;
    bit  b_pending = 0, aw_holding = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        pushes = 0; pops = 0; aw_hs_n = 0; b_n = 0; w_bursts = 0; w_beat = 0;
        aw_wait = 0; aw_holding = 0; b_pending = 0; exp_q.delete();
    endtask

    // One clock: drive at the falling edge, check, then account for the handshakes
    // that the next rising edge will complete.
    task automatic step();
        logic exp_rdy;
        @(negedge clk);
        start     = start_req;
        dst_addr  = start_addr;
        start_req = 0;
        s_valid   = ($urandom_range(99) < s_valid_pct);
        s_data    = src_data;
        awready   = awvalid && (aw_wait >= aw_delay);
        wready    = ($urandom_range(99) < w_ready_pct);
        bvalid    = b_pending;
        bresp     = (b_n == bad_idx) ? bad_resp : 2'b00;
        #1;
        check_eq("busy", busy, m_busy);
        check_eq("done", done, m_done_next);
        check_eq("err", err, m_err);
        exp_rdy = m_busy && ((pushes - pops) < FD) && (pushes < DS);
        check_eq("s2mm_ready", s_ready, exp_rdy);
        if (wvalid) check_eq("w_after_aw", aw_hs_n > w_bursts, 1);
        if (awvalid) check_eq("one_outstanding", aw_hs_n == b_n, 1);
        if (awvalid && aw_holding) check_eq("awaddr_stable", awaddr, aw_hold_addr);
        if (done) done_seen++;
        m_done_next = 0;

        if (start && !m_busy) begin
            model_clear();
            m_busy = 1; m_err = 0; xfer_done = 0; done_seen = 0;
            base_addr = {start_addr[31:7], 7'b0};
        end
        if (awvalid && awready) begin
            check_eq("awaddr", awaddr, base_addr + 32'(aw_hs_n * 128));
            check_eq("aw_attr", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser},
                     {3'b100, 4'(BS - 1), 3'b011, 2'b01, 2'b00, 4'b0001, 3'b000, 4'b0000, 5'b0});
            aw_hs_n++; aw_holding = 0; aw_wait = 0;
        end else if (awvalid) begin
            aw_holding = 1; aw_hold_addr = awaddr; aw_wait++;
        end
        if (wvalid && wready) begin
            check_eq("w_has_data", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("wdata", wdata, exp_q.pop_front());
            check_eq("wlast", wlast, w_beat == BS - 1);
            check_eq("w_attr", {wid, wstrb, wuser}, {3'b100, 8'hFF, 5'b0});
            pops++;
            if (w_beat == BS - 1) begin
                w_beat = 0; w_bursts++; b_pending = 1;
            end else begin
                w_beat++;
            end
        end
        if (bvalid && bready) begin
            b_pending = 0;
            if (bresp != 2'b00) m_err = 1;
            b_n++;
            if (b_n == NB) begin
                m_busy = 0; m_done_next = 1; xfer_done = 1;
            end
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            pushes++;
            src_data = {$urandom, $urandom};
        end
    endtask

    task automatic run_xfer(input logic [31:0] addr, input bit mid_start);
        int cyc;
        start_addr = addr;
        start_req  = 1;
        step();
        cyc = 0;
        while (!xfer_done && cyc < 4000) begin
            if (mid_start && cyc == 50) begin
                start_req = 1; start_addr = 32'hDEAD_0000;
            end
            step();
            cyc++;
        end
        check_eq("xfer_complete", xfer_done, 1);
        step();
        step();
        check_eq("beats_accepted", pushes, DS);
        check_eq("w_beats", pops, DS);
        check_eq("aw_count", aw_hs_n, NB);
        check_eq("b_count", b_n, NB);
        check_eq("done_pulses", done_seen, 1);
    endtask

    initial begin
        int cyc;
        #1;
        check_eq("reset_outputs", {awvalid, wvalid, bready, busy, done, err, s_ready, wlast, awaddr}, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Always-ready slave, continuous stream
        run_xfer(32'h1000_0000, 0);
        // Unaligned destination rounds down to 128 bytes
        run_xfer(32'h1000_0045, 0);
        // Slow AW, random W back-pressure, bursty stream
        aw_delay = 5; w_ready_pct = 60; s_valid_pct = 40;
        run_xfer($urandom, 0);
        // Error response on the second burst
        bad_idx = 1; aw_delay = 2; w_ready_pct = 70; s_valid_pct = 70;
        run_xfer(32'h2000_0100, 0);
        check_eq("err_after_bad_resp", err, 1);
        // Over-offered stream, FIFO filling, ignored mid-transfer start
        bad_idx = -1; aw_delay = 5; w_ready_pct = 50; s_valid_pct = 100;
        run_xfer(32'h3000_0000, 1);
        check_eq("err_cleared", err, 0);

        // Asynchronous reset in the middle of a data phase
        aw_delay = 0; w_ready_pct = 50; s_valid_pct = 100;
        start_addr = 32'h4000_0000; start_req = 1;
        step();
        cyc = 0;
        while (!(wvalid && pops >= 20) && cyc < 4000) begin
            step();
            cyc++;
        end
        check_eq("reached_data", wvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {awvalid, wvalid, bready, busy, done, err, s_ready, wlast, awaddr}, 0);
        model_clear();
        m_busy = 0; m_err = 0; m_done_next = 0; xfer_done = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        w_ready_pct = 80;
        run_xfer(32'h5000_0080, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/s2mm_dma_module.md
Name: s2mm_dma_module

Overview:
Write-direction DMA: accepts a 64-bit valid/ready input stream and writes it to memory over the AXI3 ACP master write channels (AW/W/B) as fixed-length INCR bursts. It is the stream-to-memory counterpart of the existing mm2s read DMA and sits between the accelerator output stream and the Zynq ACP port. One transfer of DATA_SIZE beats runs per start pulse, with at most one outstanding burst at a time.

Parameters:
DATA_SIZE, 345600, beats per transfer (1280*720*3/8); must be a multiple of BURST_SIZE
DATA_SIZE_LOG, 19, width of beat counters; 2^DATA_SIZE_LOG > DATA_SIZE
BURST_SIZE, 16, beats per burst (1..16, AXI3 limit)
FIFO_DEPTH, 32, input buffer entries; power of 2 and >= BURST_SIZE

Ports:
m_axi_acp_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a transfer when idle
dst_addr  in  32  destination byte address, sampled on an accepted start
busy  out  1  high from accepted start until the final B is received
done  out  1  one-cycle pulse on the final B handshake
err  out  1  sticky; set if any bresp != 2'b00, cleared on accepted start
m_axi_acp_awid  out  3  fixed 3'b100
m_axi_acp_awaddr  out  32  burst address
m_axi_acp_awlen  out  4  BURST_SIZE-1
m_axi_acp_awsize  out  3  3'b011 (8 bytes)
m_axi_acp_awburst  out  2  2'b01 INCR
m_axi_acp_awlock  out  2  2'b00
m_axi_acp_awcache  out  4  4'b0001
m_axi_acp_awprot  out  3  3'b000
m_axi_acp_awqos  out  4  4'b0000
m_axi_acp_awuser  out  5  5'b00000
m_axi_acp_awvalid  out  1  AW valid
m_axi_acp_awready  in  1  AW ready
m_axi_acp_wid  out  3  fixed 3'b100
m_axi_acp_wdata  out  64  FIFO head
m_axi_acp_wstrb  out  8  8'hFF
m_axi_acp_wlast  out  1  last beat of burst
m_axi_acp_wuser  out  5  5'b00000
m_axi_acp_wvalid  out  1  W valid
m_axi_acp_wready  in  1  W ready
m_axi_acp_bid  in  3  ignored
m_axi_acp_bresp  in  2  write response
m_axi_acp_buser  in  5  ignored
m_axi_acp_bvalid  in  1  B valid
m_axi_acp_bready  out  1  B ready
s2mm_data  in  64  stream data
s2mm_valid  in  1  stream valid
s2mm_ready  out  1  stream ready

Behaviour:
- Reset (async assert, sync release): state IDLE; awvalid, wvalid, bready, busy, done, err = 0; FIFO empty; all counters 0; awaddr = 0.
- start accepted only in IDLE; ignored while busy. On acceptance: awaddr <= {dst_addr[31:7], 7'b0} (128-byte alignment, so bursts never cross 4 KB), beats_in <= 0, bursts_done <= 0, err <= 0, busy <= 1.
- s2mm_ready = busy && FIFO not full && beats_in < DATA_SIZE. A push occurs on s2mm_valid && s2mm_ready; beats_in increments per push. Beats beyond DATA_SIZE are never accepted.
- FIFO: simultaneous push and pop in one cycle leaves the count unchanged; the head is presented combinationally on wdata.
- FSM:
  - IDLE -> FILL on accepted start.
  - FILL: when fifo_count >= BURST_SIZE, assert awvalid next cycle -> ADDR.
  - ADDR: hold awvalid and awaddr stable until awready; on handshake awvalid <= 0 -> DATA. W is never issued before its AW handshake.
  - DATA: wvalid = 1 while FIFO is non-empty. Pop on wvalid && wready. A 4-bit beat counter drives wlast on beat BURST_SIZE-1. After the wlast handshake, wvalid <= 0 -> RESP.
  - RESP: bready = 1. On bvalid: err |= (bresp != 0); bursts_done++; awaddr += BURST_SIZE*8. If bursts_done+1 == DATA_SIZE/BURST_SIZE, pulse done, clear busy -> IDLE; else -> FILL.
- Latency: a burst whose data is already buffered issues awvalid 1 cycle after entering FILL. Throughput is limited to one burst per AW+W+B round trip.
- An error response does not abort the transfer; all bursts are still issued.
- Reset mid-transfer abandons the outstanding burst immediately; no completion is attempted.

Test Plan:
- Reset then start with dst_addr=32'h1000_0000, DATA_SIZE=64, always-ready slave, stream valid every cycle -> 4 AW with addrs 0x1000_0000/0080/0100/0180, awlen=15, 64 W beats with wlast on every 16th, data in order, done pulse once, err=0.
- dst_addr=32'h1000_0045 -> first awaddr=32'h1000_0000.
- Slave delays awready 5 cycles and toggles wready randomly; stream bursty -> awaddr stable while awvalid is high, no wvalid before AW handshake, no beat lost or duplicated, FIFO never overflows (s2mm_ready low at 32 entries).
- Second burst returns bresp=2'b10 -> err=1 after that B, remaining bursts still issued, done pulses; next start clears err.
- Stream offers 70 beats with DATA_SIZE=64 -> exactly 64 accepted, s2mm_ready stays 0 after the 64th; start pulsed mid-transfer is ignored.
- Assert axi_resetn=0 during DATA state -> all outputs 0 asynchronously; a fresh start then completes normally.
